// File: rtl/scan_pkg.sv
// Shared definitions for the scan scheduler: table geometry, widths and FSM encoding.
package scan_pkg;

  localparam int TBL_DEPTH = 8;
  localparam int TBL_AW    = 3;
  localparam int WORD_W    = 16;
  localparam int REP_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_START = 3'd3,
    ST_ARM   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic              choice;
    logic [WORD_W-1:0] word;
  } tbl_entry_t;

  // A requested repetition count of zero still runs one scan.
  function automatic logic [REP_W-1:0] rep_target(input logic [REP_W-1:0] n);
    return (n == '0) ? REP_W'(1) : n;
  endfunction

endpackage

// File: rtl/scan_tbl.sv
// Load table: TBL_DEPTH entries of {choice, word}, synchronous write, combinational read.
module scan_tbl
  import scan_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              we,
  input  logic [TBL_AW-1:0] waddr,
  input  tbl_entry_t        wdata,
  input  logic [TBL_AW-1:0] raddr,
  output tbl_entry_t        rdata
);

  tbl_entry_t [TBL_DEPTH-1:0] mem;

  for (genvar i = 0; i < TBL_DEPTH; i++) begin : g_ent
    always_ff @(posedge clk_sys) begin
      if (rst)
        mem[i] <= '0;
      else if (we && (waddr == TBL_AW'(i)))
        mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scan_sched.sv
// Scan scheduler: loads table entries into the scan state machine, then runs
// rep_num scans, each started by scanstart and ended by a low scan_over_n.
module scan_sched
  import scan_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [TBL_AW-1:0] cfg_addr,
  input  logic              cfg_choice,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic [TBL_AW-1:0] cfg_len,
  input  logic [REP_W-1:0]  rep_num,
  input  logic              go,
  input  logic              abort,
  input  logic              scan_over_n,
  output logic              scanload,
  output logic              scanchoice,
  output logic [WORD_W-1:0] datain,
  output logic              scanstart,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  rep_cnt
);

  state_t            state;
  logic [TBL_AW-1:0] idx;
  logic [TBL_AW-1:0] len_q;
  logic [REP_W-1:0]  rep_tgt;
  logic [REP_W-1:0]  rep_nxt;
  logic [TBL_AW-1:0] rd_addr;
  logic              tbl_we;
  tbl_entry_t        wentry;
  tbl_entry_t        rd_entry;

  // Outputs are registered, so the read address looks one entry ahead:
  // entry 0 while idle (go), idx+1 while in GAP (next LOAD).
  assign rd_addr = (state == ST_GAP) ? idx + TBL_AW'(1) : '0;
  assign tbl_we  = cfg_we & ~busy;
  assign wentry  = '{choice: cfg_choice, word: cfg_data};
  assign rep_nxt = rep_cnt + REP_W'(1);

  scan_tbl u_tbl (
    .clk_sys (clk_sys),
    .rst     (rst),
    .we      (tbl_we),
    .waddr   (cfg_addr),
    .wdata   (wentry),
    .raddr   (rd_addr),
    .rdata   (rd_entry)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      len_q      <= '0;
      rep_tgt    <= '0;
      rep_cnt    <= '0;
      scanload   <= 1'b0;
      scanchoice <= 1'b0;
      datain     <= '0;
      scanstart  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      // rep_cnt is deliberately left alone so the partial count stays visible.
      state      <= ST_IDLE;
      idx        <= '0;
      scanload   <= 1'b0;
      scanchoice <= 1'b0;
      datain     <= '0;
      scanstart  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      scanload   <= 1'b0;
      scanchoice <= 1'b0;
      datain     <= '0;
      scanstart  <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            len_q      <= cfg_len;
            rep_tgt    <= rep_target(rep_num);
            rep_cnt    <= '0;
            idx        <= '0;
            state      <= ST_LOAD;
            busy       <= 1'b1;
            scanload   <= 1'b1;
            scanchoice <= rd_entry.choice;
            datain     <= rd_entry.word;
          end
        end
        ST_LOAD: state <= ST_GAP;
        ST_GAP: begin
          if (idx == len_q) begin
            state     <= ST_START;
            scanstart <= 1'b1;
          end else begin
            idx        <= idx + TBL_AW'(1);
            state      <= ST_LOAD;
            scanload   <= 1'b1;
            scanchoice <= rd_entry.choice;
            datain     <= rd_entry.word;
          end
        end
        ST_START: state <= ST_ARM;
        // A low left over from the previous scan must clear before counting.
        ST_ARM: if (scan_over_n) state <= ST_WAIT;
        ST_WAIT: begin
          if (!scan_over_n) begin
            rep_cnt <= rep_nxt;
            if (rep_nxt == rep_tgt) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_START;
              scanstart <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
